// File: rtl/smg_scan_module.sv
// Four-digit common-anode 7-segment scanner: frame-latched BCD snapshot, per-slot ghost blanking,
// decimal points, leading-zero blanking and a '-' marker for non-BCD nibbles. Outputs lag the slot counter by one cycle.
module smg_scan_module #(
  parameter int T_SCAN  = 50_000,
  parameter int T_BLANK = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] NumberSig,
  input  logic [3:0]  DotSig,
  input  logic        LzbEn,
  output logic [7:0]  Smg_Data,
  output logic [3:0]  Scan_Sig,
  output logic        FrameDone
);

  localparam int CW = (T_SCAN > 1) ? $clog2(T_SCAN) : 1;

  logic [CW-1:0] c1;
  logic [1:0]    idx;
  logic [15:0]   shNum;
  logic [3:0]    shDot;
  logic          shLzb;

  logic          slotEnd;
  logic          frameEnd;
  logic          onPhase;
  logic          lzbBlank;
  logic [3:0]    nib;
  logic [7:0]    segPat;

  assign slotEnd  = (c1 == CW'(T_SCAN - 1));
  assign frameEnd = slotEnd && (idx == 2'd3);
  assign onPhase  = (c1 >= CW'(T_BLANK));

  always_comb begin
    nib      = 4'h0;
    lzbBlank = 1'b0;
    case (idx)
      2'd0: nib = shNum[3:0];
      2'd1: nib = shNum[7:4];
      2'd2: nib = shNum[11:8];
      2'd3: nib = shNum[15:12];
      default: nib = 4'h0;
    endcase

    // A digit is blanked only when it and every digit to its left are zero.
    case (idx)
      2'd3: lzbBlank = shLzb && (shNum[15:12] == 4'h0);
      2'd2: lzbBlank = shLzb && (shNum[15:8]  == 8'h00);
      2'd1: lzbBlank = shLzb && (shNum[15:4]  == 12'h000);
      default: lzbBlank = 1'b0;
    endcase

    case (nib)
      4'h0: segPat = 8'hC0;
      4'h1: segPat = 8'hF9;
      4'h2: segPat = 8'hA4;
      4'h3: segPat = 8'hB0;
      4'h4: segPat = 8'h99;
      4'h5: segPat = 8'h92;
      4'h6: segPat = 8'h82;
      4'h7: segPat = 8'hF8;
      4'h8: segPat = 8'h80;
      4'h9: segPat = 8'h90;
      default: segPat = 8'hBF;
    endcase
    if (shDot[idx]) segPat[7] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      c1        <= '0;
      idx       <= 2'd0;
      shNum     <= 16'h0000;
      shDot     <= 4'h0;
      shLzb     <= 1'b0;
      Scan_Sig  <= 4'hF;
      Smg_Data  <= 8'hFF;
      FrameDone <= 1'b0;
    end else begin
      c1        <= slotEnd ? '0 : c1 + 1'b1;
      FrameDone <= frameEnd;
      if (slotEnd) idx <= idx + 2'd1;
      // Shadow update lands together with the wrap, so digit 0 of the next frame sees it.
      if (frameEnd) begin
        shNum <= NumberSig;
        shDot <= DotSig;
        shLzb <= LzbEn;
      end
      if (onPhase && !lzbBlank) begin
        Scan_Sig <= ~(4'b0001 << idx);
        Smg_Data <= segPat;
      end else begin
        Scan_Sig <= 4'hF;
        Smg_Data <= 8'hFF;
      end
    end
  end

endmodule
